// File: rtl/zdelta_pkg.sv
// Shared definitions for the zdelta plane sequencer: plane geometry, FSM states
// and the packed lane-bank type.
package zdelta_pkg;
  localparam int LANES = 20;
  localparam int W     = 16;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    CAPTURE,
    DRAIN
  } state_t;

  typedef logic [LANES-1:0][W-1:0] lane_bank_t;
endpackage

// File: rtl/zdelta_lane_bank.sv
// LANES x W register bank: clear, full-parallel load or single indexed write,
// in that priority order.
module zdelta_lane_bank #(
  parameter int LANES = zdelta_pkg::LANES,
  parameter int W     = zdelta_pkg::W,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               ld_en,
  input  logic [LANES*W-1:0] ld_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [W-1:0]       wr_data,
  output logic [LANES*W-1:0] q
);

  // NOTE: the bank is an ordinary flop array, so it is reset; a RAM-mapped
  // memory would be left unreset and cleared by a sequenced write instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld_en) begin
      q <= ld_data;
    end else if (wr_en) begin
      q[wr_idx*W +: W] <= wr_data;
    end
  end

endmodule

// File: rtl/zdelta_plane_seq.sv
// Frame sequencer around a fixed-latency zdelta core: loads a plane word by word,
// holds it for the core, captures the result as output and feedback, then drains it.
module zdelta_plane_seq #(
  parameter int LANES    = zdelta_pkg::LANES,
  parameter int W        = zdelta_pkg::W,
  parameter int CORE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W-1:0]       s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [W-1:0]       m_data,
  output logic               m_last,
  output logic [LANES*W-1:0] core_in,
  output logic [LANES*W-1:0] core_fb,
  input  logic [LANES*W-1:0] core_out,
  input  logic               fb_clear,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic               err_len
);
  import zdelta_pkg::*;

  localparam int               IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [3:0]       LAT      = 4'(CORE_LAT);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [3:0]         run_cnt, run_cnt_nx;
  logic               in_wr, in_ld, fb_clr, capture, frame_done, len_err;
  logic [LANES*W-1:0] in_q, fb_q, out_q, trunc_data;

  // NOTE: every output of this block is given a default first so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    run_cnt_nx = run_cnt;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_data     = '0;
    in_wr      = 1'b0;
    in_ld      = 1'b0;
    fb_clr     = 1'b0;
    capture    = 1'b0;
    frame_done = 1'b0;
    len_err    = 1'b0;
    unique case (state)
      LOAD: begin
        s_ready = 1'b1;
        fb_clr  = fb_clear;
        if (s_valid) begin
          if (idx == LAST_IDX) begin
            in_wr      = 1'b1;
            len_err    = !s_last;
            state_nx   = RUN;
            idx_nx     = '0;
            run_cnt_nx = LAT;
          end else if (s_last) begin
            // Early end of frame: the whole bank is reloaded with the tail zeroed.
            in_ld      = 1'b1;
            len_err    = 1'b1;
            state_nx   = RUN;
            idx_nx     = '0;
            run_cnt_nx = LAT;
          end else begin
            in_wr  = 1'b1;
            idx_nx = idx + 1'b1;
          end
        end
      end
      RUN: begin
        if (run_cnt <= 4'd1) begin
          state_nx   = CAPTURE;
          run_cnt_nx = '0;
        end else begin
          run_cnt_nx = run_cnt - 4'd1;
        end
      end
      CAPTURE: begin
        capture  = 1'b1;
        state_nx = DRAIN;
        idx_nx   = '0;
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = out_q[idx*W +: W];
        m_last  = (idx == LAST_IDX);
        if (m_ready) begin
          if (idx == LAST_IDX) begin
            frame_done = 1'b1;
            state_nx   = LOAD;
            idx_nx     = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  // Lanes below idx keep what was loaded, idx takes the final word, the rest clear.
  always_comb begin
    trunc_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(idx)) begin
        trunc_data[i*W +: W] = in_q[i*W +: W];
      end else if (i == int'(idx)) begin
        trunc_data[i*W +: W] = s_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      run_cnt   <= '0;
      frame_cnt <= '0;
      err_len   <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      run_cnt <= run_cnt_nx;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (len_err)    err_len   <= 1'b1;
    end
  end

  zdelta_lane_bank #(.LANES(LANES), .W(W), .IDX_W(IDX_W)) u_in_bank (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .ld_en(in_ld), .ld_data(trunc_data),
    .wr_en(in_wr), .wr_idx(idx), .wr_data(s_data),
    .q(in_q)
  );

  zdelta_lane_bank #(.LANES(LANES), .W(W), .IDX_W(IDX_W)) u_fb_bank (
    .clk(clk), .rst_n(rst_n), .clr(fb_clr),
    .ld_en(capture), .ld_data(core_out),
    .wr_en(1'b0), .wr_idx('0), .wr_data('0),
    .q(fb_q)
  );

  zdelta_lane_bank #(.LANES(LANES), .W(W), .IDX_W(IDX_W)) u_out_bank (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .ld_en(capture), .ld_data(core_out),
    .wr_en(1'b0), .wr_idx('0), .wr_data('0),
    .q(out_q)
  );

  assign core_in = in_q;
  assign core_fb = fb_q;
  assign busy    = (state != LOAD);

endmodule

// File: tb/tb_zdelta_plane_seq.sv
// Directed-plus-random bench for zdelta_plane_seq; the core is modelled as
// out = in + fb per lane and expected frames come from a lane-array reference.
module tb_zdelta_plane_seq;
  import zdelta_pkg::*;

  localparam int CORE_LAT = 2;
  localparam int EXP_LAT  = CORE_LAT + 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid, s_ready, s_last;
  logic [W-1:0]       s_data;
  logic               m_valid, m_ready, m_last;
  logic [W-1:0]       m_data;
  logic [LANES*W-1:0] core_in, core_fb, core_out;
  logic               fb_clear, busy, err_len;
  logic [15:0]        frame_cnt;

  lane_bank_t ci, cf, co;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] in_w  [LANES];
  logic [W-1:0] exp_q [LANES];
  logic [W-1:0] fb_m  [LANES];
  logic [15:0]  exp_frames;
  logic         exp_err;

  always #5 clk = ~clk;

  zdelta_plane_seq #(.LANES(LANES), .W(W), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_in(core_in), .core_fb(core_fb), .core_out(core_out),
    .fb_clear(fb_clear), .busy(busy), .frame_cnt(frame_cnt), .err_len(err_len)
  );

  // Core stand-in: corrected plane is input plus feedback, lane by lane.
  assign ci       = core_in;
  assign cf       = core_fb;
  assign core_out = co;
  always_comb begin
    co = '0;
    for (int i = 0; i < LANES; i++) co[i] = ci[i] + cf[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_frame(input int n, input bit last_end, input bit clr);
    logic [W-1:0] lane;
    for (int i = 0; i < LANES; i++) begin
      lane = (i < n) ? in_w[i] : '0;
      if (clr) fb_m[i] = '0;
      exp_q[i] = lane + fb_m[i];
      fb_m[i]  = exp_q[i];
    end
    if (n < LANES || !last_end) exp_err = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LANES; i++) fb_m[i] = '0;
    exp_frames = '0;
    exp_err    = 1'b0;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"},   s_ready,   1);
    check({tag, "_m_valid"},   m_valid,   0);
    check({tag, "_m_last"},    m_last,    0);
    check({tag, "_m_data"},    m_data,    0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_err_len"},   err_len,   0);
    check({tag, "_core_in"},   |core_in,  0);
    check({tag, "_core_fb"},   |core_fb,  0);
  endtask

  task automatic send_frame(input int n, input bit last_end, input int clr_beat);
    int t;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      t = 0;
      while (!s_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (k == 0) check("s_ready_load", s_ready, 1);
      s_valid  = 1'b1;
      s_data   = in_w[k];
      s_last   = last_end && (k == n - 1);
      fb_clear = (k == clr_beat);
    end
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic drain_frame(input string name, input int mode, input int stop_after);
    int cyc, beats, ph;
    logic [W-1:0] held_d;
    logic held_l, stalled;
    logic [LANES*W-1:0] in_snap;
    cyc = 0;
    m_ready = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      s_valid = 1'b0; s_last = 1'b0; fb_clear = 1'b0;
    end while (!m_valid && cyc < 100);
    check({name, "_latency"}, cyc, EXP_LAT);
    in_snap = core_in;
    beats = 0; ph = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (beats < stop_after && cyc < 1000) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
      check({name, "_m_valid"}, m_valid, 1);
      check({name, "_core_in_hold"}, core_in === in_snap, 1);
      if (stalled) begin
        check({name, "_stall_data"}, m_data, held_d);
        check({name, "_stall_last"}, m_last, held_l);
      end
      if (m_ready) begin
        check({name, "_m_data"}, m_data, exp_q[beats]);
        check({name, "_m_last"}, m_last, beats == LANES - 1);
        beats++;
        stalled = 1'b0;
      end else begin
        held_d  = m_data;
        held_l  = m_last;
        stalled = 1'b1;
      end
      if (beats < stop_after) begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_beats"}, beats, stop_after);
  endtask

  task automatic run_frame(input string name, input int n, input bit last_end,
                           input int clr_beat, input int mode);
    model_frame(n, last_end, clr_beat >= 0);
    send_frame(n, last_end, clr_beat);
    drain_frame(name, mode, LANES);
    @(negedge clk);
    m_ready = 1'b0;
    exp_frames = exp_frames + 16'd1;
    check({name, "_done_m_valid"}, m_valid,   0);
    check({name, "_done_s_ready"}, s_ready,   1);
    check({name, "_done_busy"},    busy,      0);
    check({name, "_frame_cnt"},    frame_cnt, exp_frames);
    check({name, "_err_len"},      err_len,   exp_err);
  endtask

  task automatic randomize_words();
    for (int i = 0; i < LANES; i++) in_w[i] = W'($urandom);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b0; fb_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Nominal frames: 1..20 then the same again accumulates feedback to 2..40.
    for (int i = 0; i < LANES; i++) in_w[i] = W'(i + 1);
    run_frame("nominal1", LANES, 1'b1, -1, 0);
    run_frame("nominal2", LANES, 1'b1, -1, 0);

    randomize_words();
    run_frame("backpressure", LANES, 1'b1, -1, 1);

    // Stand-alone fb_clear pulse in LOAD.
    @(negedge clk);
    check("fb_nonzero_before_clear", |core_fb, 1);
    fb_clear = 1'b1;
    @(negedge clk);
    fb_clear = 1'b0;
    check("fb_cleared", |core_fb, 0);
    for (int i = 0; i < LANES; i++) fb_m[i] = '0;

    randomize_words();
    run_frame("after_clear", LANES, 1'b1, -1, 2);
    randomize_words();
    run_frame("clear_with_beat", LANES, 1'b1, 3, 0);

    // Short frame: ends on the 5th word, tail lanes must drain as zero.
    randomize_words();
    in_w[4] = 16'hAAAA;
    run_frame("short", 5, 1'b1, 0, 0);
    check("short_lane19_zero", exp_q[LANES-1], 0);

    randomize_words();
    run_frame("good_after_short", LANES, 1'b1, -1, 0);
    for (int f = 0; f < 3; f++) begin
      randomize_words();
      run_frame("random", LANES, 1'b1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LANES-1)) : -1, 2);
    end

    // Reset during DRAIN after 7 accepted beats.
    randomize_words();
    model_frame(LANES, 1'b1, 1'b0);
    send_frame(LANES, 1'b1, -1);
    drain_frame("mid_reset", 0, 7);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      seen |= m_valid;
    end
    m_ready = 1'b0;
    check("mid_reset_no_m_valid", seen, 0);
    check("mid_reset_frame_cnt", frame_cnt, 0);

    // Full-length frame whose last word lacks s_last.
    randomize_words();
    run_frame("no_last", LANES, 1'b0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
